mux_rr_arb_8: RTL and testbench
===============================

MUX_RR_ARB_8 -- requirements
Module: mux_rr_arb_8

Interface
REQ-001 The block SHALL have one parameter: BURST_MAX, 4, maximum consecutive grant cycles per requester when the burst limit is compiled in (legal range 1..8).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 8, request line per requester (bit i = requester i).
REQ-005 The block SHALL have port din, input, 8, data bit per requester (d0..d7 of the shared 8:1 channel).
REQ-006 The block SHALL have port gnt, output, 8, registered one-hot grant; all-zero when idle.
REQ-007 The block SHALL have port sel, output, 3, registered select code equal to the index of the granted requester.
REQ-008 The block SHALL have port busy, output, 1, registered; high while any grant is active.
REQ-009 The block SHALL have port z, output, 1, registered muxed data: din[sel] sampled while busy.
REQ-010 The block SHALL have port z_vld, output, 1, registered; high when z carries granted data.

Function
REQ-011 The FSM SHALL have two states, IDLE (no grant) and GRANT (one requester owns the channel).
REQ-012 Arbitration SHALL be round-robin: the winner is the first set req bit searching upward from ptr and wrapping 7->0.
REQ-013 ptr SHALL be updated to (winner+1) mod 8 on every new grant.
REQ-014 IDLE->GRANT: any req bit high at a clock edge -> the next cycle has gnt one-hot for the winner, with matching sel and busy=1.
REQ-015 Release: in GRANT, req[sel]=0 at an edge -> the next cycle grants the next round-robin winner if any req is high (no idle bubble); otherwise it returns to IDLE with gnt=0 and busy=0.
REQ-016 While req[sel] stays high, the grant SHALL be held unchanged, subject only to REQ-024.
REQ-017 Each cycle: z <= busy ? din[sel] : 0 and z_vld <= busy, i.e. 1-cycle latency from grant to data.
REQ-018 A grant SHALL never change while busy except at the edges defined in REQ-015 and REQ-024; gnt SHALL always be zero or exactly one-hot.
REQ-019 A 3-bit burst counter cnt SHALL clear on every new grant and increment each held GRANT cycle, saturating at 7.
REQ-020 Simultaneous requests SHALL be resolved by REQ-012 only; requester index carries no fixed priority.
REQ-021 A request that arrives during another grant SHALL wait; no requester SHALL wait more than 7 grant tenures.

Reset
REQ-022 While rst=1, the block SHALL immediately force gnt=0, sel=0, busy=0, z=0, z_vld=0, cnt=0, ptr=0 and state IDLE, regardless of clk.
REQ-023 Assertion of rst mid-grant SHALL abort the grant with no completion cycle; the first grant after release of rst is decided from ptr=0.

Configuration
REQ-024 Macro MUX_ARB_BURST_LIMIT_EN:
- Defined: when cnt = BURST_MAX-1 and any other req bit is high, the next cycle grants the next round-robin winner even though req[sel] is still high. If no other request is pending, the grant is held and cnt clears.
- Undefined: there is no forced rotation; a grant lasts until req[sel] drops. cnt SHALL still exist but has no effect on arbitration.

Verification
REQ-025 Reset then req=8'h01 -> the next cycle gives gnt=8'h01, sel=0, busy=1; with din=8'h01, the cycle after gives z=1, z_vld=1.
REQ-026 req=8'hFF held, each owner drops req after 1 cycle -> grants sel=0,1,2,...,7,0 in consecutive tenures with no idle cycle.
REQ-027 Owner sel=5, then req=8'h21 and req[5] dropped -> next grant sel=0 (wrap past 7). With din=8'hFE, z=0 for sel=0 and z=1 for sel=5.
REQ-028 With MUX_ARB_BURST_LIMIT_EN and BURST_MAX=4, req=8'h03 held -> sel alternates 0,1 every 4 cycles. Without the macro, sel stays 0 indefinitely.
REQ-029 rst pulsed mid-grant at sel=6 -> all outputs are 0 asynchronously; after release with req=8'h41, grant goes to sel=0.
REQ-030 All req drop during GRANT -> next cycle busy=0 and gnt=0, then z_vld=0 one cycle later.

Source files
------------

// File: rtl/mux_rr_arb_8.sv
// mux_rr_arb_8: 8-requester round-robin arbiter that owns a shared 8:1 data
// channel. The granted requester's din bit appears on z one cycle after its grant.
// Optional feature: define MUX_ARB_BURST_LIMIT_EN to force rotation after
// BURST_MAX consecutive grant cycles whenever another requester is waiting.
module mux_rr_arb_8 #(
    parameter int BURST_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] din,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       busy,
    output logic       z,
    output logic       z_vld
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] sel_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic [7:0] gnt_nxt;
    logic       take_grant;
    logic [7:0] grant_set;
    logic [2:0] winner;

    // The burst length must fit the 3-bit counter.
    if (BURST_MAX < 1 || BURST_MAX > 8) begin : g_bad_burst_max
        $error("BURST_MAX must be in 1..8");
    end

    // First set bit of r searching upward from p, wrapping 7->0.
    // Scanning from the far end down lets the nearest offset win last.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        rr_pick = p;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign busy   = (state == GRANT);
    assign winner = rr_pick(grant_set, ptr);

    // Next-state and next-grant decision.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_nxt  = state;
        ptr_nxt    = ptr;
        sel_nxt    = sel;
        cnt_nxt    = cnt;
        gnt_nxt    = gnt;
        take_grant = 1'b0;
        grant_set  = req;

        unique case (state)
            IDLE: begin
                if (|req) take_grant = 1'b1;
            end
            GRANT: begin
                if (!req[sel]) begin
                    // Owner released: hand over without a bubble, or go idle.
                    if (|req) begin
                        take_grant = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = 8'h00;
                        cnt_nxt   = 3'd0;
                    end
                end else begin
`ifdef MUX_ARB_BURST_LIMIT_EN
                    if (cnt == 3'(BURST_MAX - 1)) begin
                        // Burst exhausted: rotate only if someone else waits.
                        if (|(req & ~gnt)) begin
                            take_grant = 1'b1;
                            grant_set  = req & ~gnt;
                        end else begin
                            cnt_nxt = 3'd0;
                        end
                    end else begin
                        cnt_nxt = (cnt == 3'd7) ? cnt : cnt + 3'd1;
                    end
`else
                    cnt_nxt = (cnt == 3'd7) ? cnt : cnt + 3'd1;
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (take_grant) begin
            state_nxt = GRANT;
            sel_nxt   = winner;
            gnt_nxt   = 8'h01 << winner;
            ptr_nxt   = winner + 3'd1;
            cnt_nxt   = 3'd0;
        end
    end

    // Arbitration state register; reset aborts any grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 3'd0;
            sel   <= 3'd0;
            cnt   <= 3'd0;
            gnt   <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
        end
    end

    // Muxed data path: one cycle behind the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z     <= 1'b0;
            z_vld <= 1'b0;
        end else begin
            z     <= busy ? din[sel] : 1'b0;
            z_vld <= busy;
        end
    end

endmodule

// File: tb/tb_mux_rr_arb_8.sv
// Self-checking bench for mux_rr_arb_8: directed scenarios plus randomized
// traffic compared against an integer-level arbitration model.
module tb_mux_rr_arb_8;

    localparam int BURST_MAX = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       z;
    logic       z_vld;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (plain integers).
    int m_busy, m_sel, m_ptr, m_cnt, m_z, m_zvld;

    mux_rr_arb_8 #(.BURST_MAX(BURST_MAX)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .sel   (sel),
        .busy  (busy),
        .z     (z),
        .z_vld (z_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int find_winner(input logic [7:0] r, input int start);
        for (int i = 0; i < 8; i++) begin
            if (r[(start + i) % 8]) return (start + i) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0; m_z = 0; m_zvld = 0;
    endtask

    task automatic model_grant(input int w);
        m_busy = 1; m_sel = w; m_ptr = (w + 1) % 8; m_cnt = 0;
    endtask

    // Advance the model by one clock edge using the current req/din.
    task automatic model_edge();
        logic [7:0] other;
        m_z    = m_busy ? int'(din[m_sel]) : 0;
        m_zvld = m_busy;
        if (m_busy == 0) begin
            if (req != 0) model_grant(find_winner(req, m_ptr));
        end else if (!req[m_sel]) begin
            if (req != 0) model_grant(find_winner(req, m_ptr));
            else begin m_busy = 0; m_cnt = 0; end
        end else begin
`ifdef MUX_ARB_BURST_LIMIT_EN
            other = req & ~(8'h01 << m_sel);
            if (m_cnt == BURST_MAX - 1) begin
                if (other != 0) model_grant(find_winner(other, m_ptr));
                else m_cnt = 0;
            end else begin
                m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
            end
`else
            other = 8'h00;
            m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
`endif
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".gnt"},  gnt,   m_busy ? (32'h1 << m_sel) : 32'h0);
        check({tag, ".busy"}, busy,  m_busy);
        if (m_busy != 0) check({tag, ".sel"}, sel, m_sel);
        check({tag, ".z"},    z,     m_z);
        check({tag, ".zvld"}, z_vld, m_zvld);
    endtask

    // One clock: model follows the edge, outputs sampled 1 ns later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst.gnt", gnt, 0);
        check("rst.sel", sel, 0);
        check("rst.busy", busy, 0);
        check("rst.z", z, 0);
        check("rst.zvld", z_vld, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = 8'h00;
        din = 8'h00;
        #2;
        do_reset();

        // Single requester, data appears one cycle after grant.
        req = 8'h01; din = 8'h01;
        step("r025a");
        check("r025.gnt", gnt, 8'h01);
        check("r025.sel", sel, 0);
        check("r025.busy", busy, 1);
        step("r025b");
        check("r025.z", z, 1);
        check("r025.zvld", z_vld, 1);

        // All requesting, each owner releases after one cycle: 0..7 then 0.
        do_reset();
        req = 8'hFF;
        step("r026g");
        check("r026.sel0", sel, 0);
        for (int k = 1; k <= 8; k++) begin
            req = 8'hFF & ~(8'h01 << ((k - 1) % 8));
            step("r026");
            check($sformatf("r026.sel%0d", k), sel, k % 8);
            check($sformatf("r026.busy%0d", k), busy, 1);
        end

        // Wrap past 7 from owner 5; z follows din[sel] one cycle late.
        do_reset();
        din = 8'hFE;
        req = 8'h20;
        step("r027a");
        check("r027.sel5", sel, 5);
        req = 8'h21;
        step("r027b");
        check("r027.z5", z, 1);
        req = 8'h01;
        step("r027c");
        check("r027.sel0", sel, 0);
        step("r027d");
        check("r027.z0", z, 0);

        // Two requesters held continuously.
        do_reset();
        req = 8'h03;
        for (int k = 0; k < 12; k++) begin
            step("r028");
`ifdef MUX_ARB_BURST_LIMIT_EN
            check($sformatf("r028.sel%0d", k), sel, (k / 4) % 2);
`else
            check($sformatf("r028.sel%0d", k), sel, 0);
`endif
        end

        // Asynchronous reset in the middle of a grant at sel=6.
        do_reset();
        req = 8'h40;
        step("r029a");
        check("r029.sel6", sel, 6);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("r029.gnt", gnt, 0);
        check("r029.busy", busy, 0);
        check("r029.z", z, 0);
        check("r029.zvld", z_vld, 0);
        check("r029.sel", sel, 0);
        #1;
        rst = 1'b0;
        req = 8'h41;
        step("r029b");
        check("r029.sel0", sel, 0);

        // Every request drops during a grant.
        req = 8'h00;
        step("r030a");
        check("r030.busy", busy, 0);
        check("r030.gnt", gnt, 0);
        check("r030.zvld1", z_vld, 1);
        step("r030b");
        check("r030.zvld0", z_vld, 0);

        // Randomized traffic: owners usually hold, others come and go.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            req = 8'($urandom) & 8'($urandom);
            if (m_busy != 0 && $urandom_range(3) != 0) req[m_sel] = 1'b1;
            if ($urandom_range(15) == 0) req = 8'h00;
            din = 8'($urandom);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
